// File: rtl/execute_alu_arbiter_if.sv
// Execute-stage ALU sharing bus: requester operands and requests in,
// grant/muxed ALU inputs and lock status out.
interface execute_alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 5,
    parameter int OPND_W  = 33
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*OPND_W-1:0] req_in_a;
    logic [NUM_REQ*OPND_W-1:0] req_in_b;
    logic [NUM_REQ*OP_W-1:0]   req_alu_op;

    logic [NUM_REQ-1:0]        grant;
    logic [OPND_W-1:0]         alu_in_a;
    logic [OPND_W-1:0]         alu_in_b;
    logic [OP_W-1:0]           alu_op;
    logic                      alu_valid;
    logic                      locked;
    logic [IDX_W-1:0]          lock_owner;
    logic                      lock_overrun;

    // Requester side: drives requests and operands, observes grant and status.
    modport master (
        output req_valid, req_lock, req_in_a, req_in_b, req_alu_op,
        input  grant, alu_in_a, alu_in_b, alu_op, alu_valid,
               locked, lock_owner, lock_overrun
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_lock, req_in_a, req_in_b, req_alu_op,
        output grant, alu_in_a, alu_in_b, alu_op, alu_valid,
               locked, lock_owner, lock_overrun
    );
endinterface

// File: rtl/execute_alu_arbiter.sv
// Round-robin arbiter sharing the single execute-stage ALU between execute
// units, with a bounded lock so multi-cycle users can hold the ALU.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARBITRATE | no reservation; grant first valid requester from rr_ptr
// LOCKED    | ALU reserved for lock_owner while it keeps req_valid high
module execute_alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int OP_W        = 5,
    parameter int OPND_W      = 33,
    parameter int LOCK_MAX    = 4,
    parameter int ALU_IDLE_OP = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    execute_alu_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ARBITRATE = 1'b0,
        LOCKED    = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  lock_owner_q;
    logic [CNT_W-1:0]  lock_cnt;
    logic              lock_overrun_q;

    logic              rr_hit;
    logic [IDX_W-1:0]  rr_idx;
    logic [IDX_W-1:0]  cand;
    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;
    logic              owner_hold;
    logic              limit_hit;
    logic [IDX_W-1:0]  next_ptr;
    logic [NUM_REQ-1:0] grant_vec;
    logic [OPND_W-1:0] mux_a;
    logic [OPND_W-1:0] mux_b;
    logic [OP_W-1:0]   mux_op;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = rr_ptr;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!rr_hit && bus.req_valid[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // Grant selection: a live lock owner wins outright; an abandoned lock
    // falls back to normal arbitration in the same cycle.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        owner_hold = 1'b0;
        if (!flush) begin
            if (state == LOCKED && bus.req_valid[lock_owner_q]) begin
                grant_any  = 1'b1;
                grant_idx  = lock_owner_q;
                owner_hold = 1'b1;
            end else if (rr_hit) begin
                grant_any  = 1'b1;
                grant_idx  = rr_idx;
            end
        end
    end

    // A fresh lock only hits the limit when a single cycle is all we allow.
    assign limit_hit = owner_hold ? (lock_cnt >= CNT_W'(LOCK_MAX - 1))
                                  : (LOCK_MAX <= 1);
    assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : grant_idx + IDX_W'(1);

    // Operand/opcode mux onto the ALU; idle opcode when nothing is granted.
    always_comb begin
        grant_vec = '0;
        mux_a     = '0;
        mux_b     = '0;
        mux_op    = OP_W'(ALU_IDLE_OP);
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
            mux_a  = bus.req_in_a[int'(grant_idx)*OPND_W +: OPND_W];
            mux_b  = bus.req_in_b[int'(grant_idx)*OPND_W +: OPND_W];
            mux_op = bus.req_alu_op[int'(grant_idx)*OP_W +: OP_W];
        end
    end

    // Lock FSM, round-robin pointer and overrun pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARBITRATE;
            rr_ptr         <= '0;
            lock_owner_q   <= '0;
            lock_cnt       <= '0;
            lock_overrun_q <= 1'b0;
        end else if (flush) begin
            state          <= ARBITRATE;
            lock_cnt       <= '0;
            lock_overrun_q <= 1'b0;
        end else begin
            lock_overrun_q <= 1'b0;
            if (!grant_any) begin
                state    <= ARBITRATE;
                lock_cnt <= '0;
            end else if (bus.req_lock[grant_idx] && !limit_hit) begin
                state        <= LOCKED;
                lock_owner_q <= grant_idx;
                lock_cnt     <= owner_hold ? lock_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                // Grant ends here, either normally or by forced release.
                state          <= ARBITRATE;
                lock_cnt       <= '0;
                rr_ptr         <= next_ptr;
                lock_overrun_q <= bus.req_lock[grant_idx];
            end
        end
    end

    assign bus.grant        = grant_vec;
    assign bus.alu_in_a     = mux_a;
    assign bus.alu_in_b     = mux_b;
    assign bus.alu_op       = mux_op;
    assign bus.alu_valid    = grant_any;
    assign bus.locked       = (state == LOCKED);
    assign bus.lock_owner   = lock_owner_q;
    assign bus.lock_overrun = lock_overrun_q;
endmodule
